// File: rtl/load_unit_ctrl_pkg.sv
// Shared encodings and helpers for the load unit controller and its lane extractor.
package load_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_e;

   function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_unit_ctrl_lane_ext.sv
// Little-endian byte/halfword lane select with sign or zero extension to 32 bits.
module load_lane_ext
   import load_pkg::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        addr_lo,
   input  logic [1:0]        size,
   input  logic              is_signed,
   output logic [DATA_W-1:0] data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        fill_s;

   // Pick the addressed lane, then extend according to size and signedness.
   always_comb begin
      byte_s = 8'd0;
      half_s = 16'd0;
      fill_s = 1'b0;
      data   = 32'd0;
      case (addr_lo)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'd0;
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
      case (size)
         SZ_BYTE: begin
            fill_s = is_signed & byte_s[7];
            data   = {{24{fill_s}}, byte_s};
         end
         SZ_HALF: begin
            fill_s = is_signed & half_s[15];
            data   = {{16{fill_s}}, half_s};
         end
         SZ_WORD: data = rdata;
         default: data = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_unit_ctrl.sv
// Single-outstanding load controller: request capture, word read issue, bounded wait,
// and a held response until the consumer accepts it.
module load_unit_ctrl
   import load_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [4:0]        req_rd,
   output logic              mem_rd_en,
   output logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [4:0]        rsp_rd,
   output logic              rsp_err
);

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_e            state_q,    state_d;
   logic [7:0]        cnt_q,      cnt_d;
   logic [1:0]        addr_lo_q,  addr_lo_d;
   logic [1:0]        size_q,     size_d;
   logic              signed_q,   signed_d;
   logic [4:0]        rd_q,       rd_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q,  rsp_err_d;
   logic [DATA_W-1:0] ext_data_s;

   load_lane_ext u_lane_ext (
      .rdata     (mem_rdata),
      .addr_lo   (addr_lo_q),
      .size      (size_q),
      .is_signed (signed_q),
      .data      (ext_data_s)
   );

   // Next-state and capture logic; the response fields only change on entry to RESP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_lo_d  = addr_lo_q;
      size_d     = size_q;
      signed_d   = signed_q;
      rd_d       = rd_q;
      mem_addr_d = mem_addr_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_lo_d = req_addr[1:0];
               size_d    = req_size;
               signed_d  = req_signed;
               rd_d      = req_rd;
               if (req_is_bad(req_size, req_addr[1:0])) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = 32'd0;
                  state_d    = RESP;
               end else begin
                  mem_addr_d = {req_addr[31:2], 2'b00};
                  state_d    = ISSUE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            cnt_d   = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // Returned data takes priority over a timeout in the same cycle.
            if (mem_rvalid) begin
               rsp_data_d = ext_data_s;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if (cnt_q == TMO_LAST) begin
               rsp_data_d = 32'd0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         addr_lo_q  <= 2'd0;
         size_q     <= 2'd0;
         signed_q   <= 1'b0;
         rd_q       <= 5'd0;
         mem_addr_q <= 32'd0;
         rsp_data_q <= 32'd0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_lo_q  <= addr_lo_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         rd_q       <= rd_d;
         mem_addr_q <= mem_addr_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign mem_rd_en = (state_q == ISSUE);
   assign rsp_valid = (state_q == RESP);
   assign mem_addr  = mem_addr_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_rd    = rd_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: doc/load_unit_ctrl.md
Name: load_unit_ctrl

Overview:
- Multi-cycle load controller between the execute stage and the data memory port.
- Accepts one load request at a time and issues a word-aligned memory read with a valid/ready-style handshake.
- Selects the addressed byte or halfword lane, then sign- or zero-extends it to 32 bits and returns the result with a destination register tag.
- Detects misaligned and illegal-size requests and bounds the memory wait with a timeout.

Parameters:
- MEM_TIMEOUT, 16, cycles spent in WAIT without mem_rvalid before the request is aborted with an error; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  load request present
- req_ready  output  1  controller can accept a request
- req_addr  input  32  byte address
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  input  1  1 = sign-extend, 0 = zero-extend (ignored for word)
- req_rd  input  5  destination register tag
- mem_rd_en  output  1  one-cycle read strobe
- mem_addr  output  32  word-aligned read address
- mem_rdata  input  32  read data, valid when mem_rvalid=1
- mem_rvalid  input  1  read data return
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  32  extended load result
- rsp_rd  output  5  captured req_rd
- rsp_err  output  1  1 = misaligned, illegal size, or timeout

Behaviour:
- Reset (asynchronous, any state): state=IDLE, timeout counter=0, all captured registers=0. Outputs: req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0.
- A mem_rvalid arriving after a reset that aborted a WAIT is ignored.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- IDLE:
  - req_ready=1.
  - Accept on req_valid & req_ready: capture addr, size, signed, rd.
  - Error check on accept: size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0 -> go to RESP with rsp_err=1 and rsp_data=0. No memory access is issued.
  - Otherwise -> ISSUE.
- ISSUE:
  - mem_rd_en=1 for exactly this cycle; mem_addr = {addr[31:2], 2'b00}.
  - Clear the timeout counter, then -> WAIT.
  - mem_addr holds its value until the next ISSUE.
- WAIT:
  - Counter increments each cycle.
  - On mem_rvalid=1: register the extended data, rsp_err=0, -> RESP.
  - On counter == MEM_TIMEOUT-1 without mem_rvalid: rsp_err=1, rsp_data=0, -> RESP.
  - mem_rvalid and timeout in the same cycle: the data wins.
- RESP:
  - rsp_valid=1; rsp_data, rsp_rd and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready -> IDLE; rsp_valid=0 next cycle.
  - req_ready=0 in ISSUE, WAIT and RESP. There is no bypass: a new request is accepted no earlier than the cycle after the response handshake.
- mem_rvalid seen outside WAIT is ignored.
- Lane select (little-endian):
  - byte: lane = addr[1:0]; bits [8k+7:8k].
  - half: lane = addr[1]; bits [16k+15:16k].
  - word: pass-through.
- Extension: sign copies the lane MSB into the upper bits; zero fills the upper bits with 0.
- Latency with zero-wait memory (mem_rvalid in the cycle after mem_rd_en): accept at T, mem_rd_en at T+1, rvalid at T+2, rsp_valid at T+3.
- Misaligned path: accept at T, rsp_valid at T+1.
- Throughput: one load per 4 cycles at best.

Decomposition:
- Shared package (load_pkg):
  - size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11
  - state enum: IDLE, ISSUE, WAIT, RESP
  - constant: DATA_W=32
- One combinational sub-module, load_lane_ext:
  - inputs: rdata[31:0], addr_lo[1:0], size[1:0], signed
  - output: data[31:0]
  - performs lane select plus sign/zero extension.
- The controller holds only the FSM, counter and capture registers.

Test Plan:
- Signed byte: addr=0x1003, size=00, signed=1, rdata=0x80FFFFFF -> mem_addr=0x1000, rsp_data=0xFFFFFF80, rsp_err=0, rsp_valid at T+3.
- Unsigned half: addr=0x2002, size=01, signed=0, rdata=0xBEEF1234 -> rsp_data=0x0000BEEF; the same request with signed=1 -> 0xFFFFBEEF.
- Misaligned: half at addr=0x0001, or size=11 -> no mem_rd_en pulse, rsp_valid at T+1, rsp_err=1, rsp_data=0.
- Timeout: word at 0x0010, mem_rvalid never asserted -> rsp_err=1 after MEM_TIMEOUT WAIT cycles. A late rvalid after that is ignored, and the next request succeeds.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_rd stay stable and req_ready stays 0. A req_valid held during this time is accepted only after the handshake.
- Reset in WAIT: assert rst mid-wait, then mem_rvalid after release -> outputs return to their reset values immediately, no response is produced, and req_ready=1.
